// File: rtl/ram_pkg.sv
// Shared definitions for the initialised single-port RAM.
//   BOOT_WORDS : number of low words that take the boot image
//   BOOT_IMG   : boot image bytes, index 0 first
//   state_e    : init sequencer states
//   init_word  : word written to a given address during the init sweep
package ram_pkg;

  localparam int unsigned BOOT_WORDS = 4;

  localparam logic [7:0] BOOT_IMG [BOOT_WORDS] = '{8'hF0, 8'h0F, 8'h01, 8'h02};

  typedef enum logic {INIT, RUN} state_e;

  // Returns a 64-bit word. Callers cast it down to their data width, so
  // data widths above 64 bits are not supported.
  function automatic logic [63:0] init_word(input logic [63:0] a,
                                            input logic        boot_en,
                                            input logic [63:0] fill);
    if (boot_en && (a < 64'(BOOT_WORDS))) begin
      return {56'd0, BOOT_IMG[a[1:0]]};
    end
    return fill;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init sequencer: after reset, sweeps every address once, presenting the
// init word for each on a write port, then raises ready and stays idle.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   init_we      : write strobe for the sweep (never high while reset=1)
//   init_addr    : address being initialised
//   init_data    : init word for init_addr
//   ready        : registered, high once the sweep has completed
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          ADDR_W   = 4,
  parameter bit                   BOOT_EN  = 1'b1,
  parameter logic [DATA_W-1:0]    FILL_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state;
  logic [ADDR_W-1:0] cnt;

  // The counter parks on the last address instead of wrapping, so a
  // second sweep can only come from a new reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (cnt == LAST_ADDR) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    init_we   = (state == INIT) && !reset;
    init_addr = cnt;
    init_data = DATA_W'(init_word(64'(cnt), BOOT_EN, 64'(FILL_VAL)));
  end

endmodule

// File: rtl/ram_sp_init.sv
// Single-port synchronous RAM with a hardware init sweep after reset.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   address      : word address for reads and writes
//   data_in, we  : write data and write enable
//   rd           : read enable; data_out/rd_valid update one cycle later
//   data_out     : registered read data, holds between reads
//   rd_valid     : one-cycle pulse when data_out updates
//   ready        : high once init is complete; accesses only accepted then
//   err          : one-cycle pulse after we/rd is seen while not ready
module ram_sp_init
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter bit                BOOT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  logic [DATA_W-1:0] mem [DEPTH];

  logic user_ok;
  assign user_ok = ready && !reset;

  ram_init_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BOOT_EN  (BOOT_EN),
    .FILL_VAL (FILL_VAL)
  ) u_init_seq (
    .clock     (clock),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  // Write port mux: the sweep owns the port until ready, then the user.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (user_ok && we) begin
      mem[address] <= data_in;
    end
  end

  // Read is taken from the pre-edge contents, giving read-first behaviour
  // on a simultaneous write to the same address.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= ready && rd;
      err      <= !ready && (we || rd);
      if (ready && rd) begin
        data_out <= mem[address];
      end
    end
  end

endmodule

// File: doc/ram_sp_init.md
Name: ram_sp_init

Overview:
- Parametrised single-port synchronous RAM for the simple processor's data/program store.
- Generalises the fixed 16x8 memory in width and depth.
- Adds a hardware init sequencer: after reset it fills every word, loading the boot image into low addresses and FILL_VAL elsewhere.
- Adds a read-valid strobe, a ready flag and an access-error flag, so the control unit can handshake instead of relying on fixed timing.

Parameters:
- DATA_W, 8, data word width in bits (>= 8).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- BOOT_EN, 1: 1 = words 0..3 take the boot image after init; 0 = all words take FILL_VAL.
- FILL_VAL, 0, value written to every non-boot word during init (DATA_W bits).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset; restarts the init sweep.
- address, input, ADDR_W, word address for read/write.
- data_in, input, DATA_W, write data.
- we, input, 1, write enable, sampled at posedge.
- rd, input, 1, read enable, sampled at posedge.
- data_out, output, DATA_W, registered read data; holds its value between reads.
- rd_valid, output, 1, one-cycle pulse, high the cycle data_out updates.
- ready, output, 1, high once init completes; accesses are accepted only while high.
- err, output, 1, one-cycle pulse when we or rd is asserted while ready=0.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock.
- Reset values (cycle after reset is sampled high): data_out=0, rd_valid=0, ready=0, err=0, state=INIT, init counter=0.
- Memory contents are NOT reset directly. They are written by the INIT sweep.
- FSM, two states:
  - INIT: each cycle write init_word(cnt) to mem[cnt], then cnt++. When cnt==DEPTH-1 is written, go to RUN next cycle. Sweep takes exactly DEPTH cycles.
  - RUN: ready=1. Normal access. Stays in RUN until reset.
- init_word(a): if BOOT_EN and a<4, BOOT_IMG[a]; else FILL_VAL. BOOT_IMG = {8'hF0, 8'h0F, 8'h01, 8'h02}, zero-extended to DATA_W.
- Reset held high: FSM stays at INIT with cnt=0. No memory writes occur while reset=1.
- Reset mid-INIT or in RUN: sweep restarts from 0 and ready drops the next cycle.
- Access timing in RUN:
  - Write: we=1 at edge N gives mem[address]=data_in, visible to reads from edge N+1.
  - Read: rd=1 at edge N gives data_out=mem[address] and rd_valid=1 after edge N. Latency is 1 cycle.
  - Back-to-back reads each produce a rd_valid pulse.
- Simultaneous we and rd at the same address: read-first. data_out gets the old contents and the memory gets the new data.
- Access while ready=0 (INIT or reset): no memory change, data_out holds, rd_valid=0. err=1 for one cycle after each offending edge. During reset err stays 0, since reset wins.
- Wrap-around: address is full-width, so every value is valid. There is no out-of-range case.
- The init counter is ADDR_W bits and must not wrap into a second sweep. Terminate on cnt==DEPTH-1.

Decomposition:
- Package ram_pkg holds:
  - the BOOT_IMG constant array (4 x 8 bits)
  - BOOT_WORDS=4
  - the state typedef {INIT, RUN}
  - the init_word function.
- One natural sub-module: ram_init_seq. It contains the FSM and sweep counter and outputs init_we, init_addr, init_data and ready.
- The top level muxes the write port between ram_init_seq and the user port, and holds the storage array plus the read register.

Test Plan:
- Init timing: pulse reset 1 cycle, then keep idle. ready rises exactly DEPTH=16 cycles after reset deasserts. Reads of 0..3 return F0, 0F, 01, 02; reads of 4..15 return 00.
- Write then read: in RUN, write 8'hA5 to addr 9, then rd addr 9 the next cycle. data_out=A5 with rd_valid=1 one cycle after the rd edge; rd_valid=0 the cycle after.
- Read-first collision: mem[2]=01. Assert we=1, rd=1, addr=2, data_in=3C in the same cycle. data_out=01; a following read returns 3C.
- Access during init: assert we=1 at addr 5 with data 77 on the 3rd init cycle. err pulses 1 cycle. After ready, mem[5] reads 00 and no rd_valid occurred during init.
- Reset mid-operation: in RUN, write FF to addr 0, then assert reset. ready drops next cycle, the sweep reruns 16 cycles, and addr 0 reads F0 again.
- Parameter sweep: DATA_W=16, ADDR_W=6, BOOT_EN=0, FILL_VAL=16'h1234. ready comes after 64 cycles and all words, including 0..3, read 1234.
